// File: rtl/framebuffer_writer.sv
// framebuffer_writer: double-buffered pixel sink, swaps with scanout at vblank.
// Optional back-buffer clear to BG_COLOR is built in when FB_CLEAR_EN is defined.
module framebuffer_writer #(
   parameter int                 BUFFER_WIDTH  = 160,
   parameter int                 BUFFER_HEIGHT = 120,
   parameter int                 COLOR_W       = 12,
   parameter logic [COLOR_W-1:0] BG_COLOR      = 12'h000,
   parameter int                 X_W           = $clog2(BUFFER_WIDTH),
   parameter int                 Y_W           = $clog2(BUFFER_HEIGHT),
   parameter int                 ADDR_W        = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               pixel_s_valid,
   output logic               pixel_s_ready,
   input  logic [COLOR_W-1:0] pixel_s_color,
   input  logic [X_W-1:0]     pixel_s_x,
   input  logic [Y_W-1:0]     pixel_s_y,
   input  logic               pixel_s_last,
   output logic               fb_we,
   output logic               fb_buf,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [COLOR_W-1:0] fb_wdata,
   input  logic               vblank,
   output logic               front_buf,
   output logic               frame_done,
   output logic [15:0]        drop_count
);

   localparam int NPIX = BUFFER_WIDTH * BUFFER_HEIGHT;

   typedef enum logic [1:0] {
      CLEAR     = 2'd0,
      DRAW      = 2'd1,
      WAIT_SWAP = 2'd2
   } state_t;

`ifdef FB_CLEAR_EN
   localparam state_t RESUME = CLEAR;
`else
   localparam state_t RESUME = DRAW;
`endif

   state_t               state;
   state_t               state_d;
   logic                 ready_q;
   logic                 we_q;
   logic                 we_d;
   logic [ADDR_W-1:0]    addr_q;
   logic [ADDR_W-1:0]    addr_d;
   logic [COLOR_W-1:0]   wdata_q;
   logic [COLOR_W-1:0]   wdata_d;
   logic                 front_q;
   logic                 front_d;
   logic                 done_q;
   logic                 done_d;
   logic [15:0]          drop_q;
   logic [15:0]          drop_d;
   logic                 hs;
   logic                 in_range;
   logic [ADDR_W-1:0]    lin_addr;
`ifdef FB_CLEAR_EN
   logic [ADDR_W:0]      clr_cnt;
   logic [ADDR_W:0]      clr_cnt_d;
`endif

   assign pixel_s_ready = ready_q;
   assign fb_we         = we_q;
   assign fb_addr       = addr_q;
   assign fb_wdata      = wdata_q;
   assign front_buf     = front_q;
   assign fb_buf        = ~front_q;
   assign frame_done    = done_q;
   assign drop_count    = drop_q;

   assign hs = pixel_s_valid && ready_q;

   // range check is done at full width before the address is formed
   assign in_range = (32'(pixel_s_x) < BUFFER_WIDTH)
                  && (32'(pixel_s_y) < BUFFER_HEIGHT);

   // only used when in range, so the modular ADDR_W result is exact
   assign lin_addr = ADDR_W'(pixel_s_y) * ADDR_W'(BUFFER_WIDTH)
                   + ADDR_W'(pixel_s_x);

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= RESUME;
      end else begin
         state <= state_d;
      end
   end

   // next state and next values of the registered outputs
   always_comb begin
      state_d = state;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      front_d = front_q;
      done_d  = 1'b0;
      drop_d  = drop_q;
`ifdef FB_CLEAR_EN
      clr_cnt_d = '0;
`endif
      unique case (state)
`ifdef FB_CLEAR_EN
         CLEAR: begin
            if (clr_cnt == (ADDR_W+1)'(NPIX)) begin
               state_d = DRAW;
            end else begin
               we_d      = 1'b1;
               addr_d    = clr_cnt[ADDR_W-1:0];
               wdata_d   = BG_COLOR;
               clr_cnt_d = clr_cnt + (ADDR_W+1)'(1);
            end
         end
`endif
         DRAW: begin
            if (hs) begin
               if (in_range) begin
                  we_d    = 1'b1;
                  addr_d  = lin_addr;
                  wdata_d = pixel_s_color;
               end else if (drop_q != 16'hFFFF) begin
                  drop_d = drop_q + 16'd1;
               end
               if (pixel_s_last) begin
                  state_d = WAIT_SWAP;
               end
            end
         end
         WAIT_SWAP: begin
            if (vblank) begin
               state_d = RESUME;
               front_d = ~front_q;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = RESUME;
         end
      endcase
   end

   // registered outputs; ready follows the state being entered
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         front_q <= 1'b0;
         done_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         ready_q <= (state_d == DRAW);
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         front_q <= front_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
      end
   end

`ifdef FB_CLEAR_EN
   // clear address counter, idle at zero outside CLEAR
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         clr_cnt <= '0;
      end else begin
         clr_cnt <= clr_cnt_d;
      end
   end
`endif

endmodule

// File: doc/framebuffer_writer.md
Name: framebuffer_writer

Overview:
- Pipeline tail sink for the rasterised pixel stream leaving the math stage; the top level unpacks pixel data/metadata into flat fields.
- Writes accepted pixels into a double-buffered framebuffer memory (external dual-buffer RAM, one write port).
- Swaps front/back buffers with the VGA scanout at vblank once a frame's last pixel has been written.
- Optionally clears the new back buffer to a background colour before accepting the next frame.

Parameters:
- BUFFER_WIDTH, 160, framebuffer width in pixels
- BUFFER_HEIGHT, 120, framebuffer height in pixels
- COLOR_W, 12, pixel colour width (RGB444)
- BG_COLOR, 12'h000, clear colour
- X_W, $clog2(BUFFER_WIDTH), x coordinate width (8 at default)
- Y_W, $clog2(BUFFER_HEIGHT), y coordinate width (7 at default)
- ADDR_W, $clog2(BUFFER_WIDTH*BUFFER_HEIGHT), framebuffer address width (15 at default)

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- pixel_s_valid  in  1  pixel stream valid
- pixel_s_ready  out  1  pixel stream ready
- pixel_s_color  in  COLOR_W  pixel colour
- pixel_s_x  in  X_W  pixel column
- pixel_s_y  in  Y_W  pixel row
- pixel_s_last  in  1  last pixel of frame
- fb_we  out  1  framebuffer write enable
- fb_buf  out  1  buffer index being written (always = back buffer)
- fb_addr  out  ADDR_W  write address
- fb_wdata  out  COLOR_W  write data
- vblank  in  1  single-cycle pulse from scanout at start of vertical blank
- front_buf  out  1  buffer index scanout must read
- frame_done  out  1  single-cycle pulse on buffer swap
- drop_count  out  16  saturating count of out-of-range pixels since reset

Behaviour:
- Reset (async, rstn=0): front_buf=0, fb_buf=1, fb_we=0, fb_addr=0, fb_wdata=0, pixel_s_ready=0, frame_done=0, drop_count=0; state=CLEAR when FB_CLEAR_EN is defined, otherwise DRAW.
- Reset asserted mid-operation aborts any clear or draw immediately; no partial state is retained.
- States:
  - CLEAR: fb_we=1 and fb_wdata=BG_COLOR every cycle. fb_addr counts 0..W*H-1, one address per cycle. On the cycle writing address W*H-1, the next state is DRAW. pixel_s_ready=0.
  - DRAW: pixel_s_ready=1, registered from the state.
    - On handshake (valid&&ready) in cycle N, cycle N+1 has fb_we=1, fb_addr=y*BUFFER_WIDTH+x, fb_wdata=colour. Latency is 1 cycle.
    - A pixel with x>=BUFFER_WIDTH or y>=BUFFER_HEIGHT is still accepted. It produces no write (fb_we=0) and increments drop_count, which saturates at 16'hFFFF.
    - A handshake with last=1 moves the state to WAIT_SWAP next cycle, whether or not that pixel was in range. pixel_s_ready drops in that same next cycle.
  - WAIT_SWAP: pixel_s_ready=0, fb_we=0 except the trailing write of the last pixel.
    - On vblank=1: next cycle front_buf toggles, fb_buf toggles, frame_done=1 for one cycle, and the state goes to CLEAR (or DRAW without FB_CLEAR_EN).
    - A vblank arriving in the same cycle the state enters WAIT_SWAP is honoured. Internally, a handshake with last=1 in cycle N followed by vblank in cycle N+1 swaps in cycle N+2.
- vblank in CLEAR or DRAW is ignored; it is not queued.
- fb_buf is always the complement of front_buf; the writer never writes the displayed buffer.
- Address arithmetic: y*BUFFER_WIDTH is a constant multiply; the result is truncated to ADDR_W only after the range check.
- Back-to-back pixels: one pixel accepted per cycle with no bubbles in DRAW.
- Duplicate coordinates: the later pixel overwrites the earlier one (painter order).
- Empty frame: a single pixel with last=1 and an out-of-range coordinate is a valid frame and causes a swap.

Optional Feature:
- FB_CLEAR_EN defined: CLEAR state exists and runs after reset and after every swap, taking W*H cycles (19200 at default) before ready rises.
- FB_CLEAR_EN undefined: no CLEAR state. After reset and after a swap the state goes directly to DRAW, the back buffer keeps its stale contents, and BG_COLOR is unused.

Test Plan:
- Reset then idle, FB_CLEAR_EN on -> 19200 consecutive writes of 12'h000 to fb_buf=1, addresses 0..19199, then pixel_s_ready=1 on the following cycle.
- Pixel (x=5, y=2, colour 12'hF0A), last=0, in DRAW -> one cycle later fb_we=1, fb_addr=325, fb_wdata=12'hF0A, fb_buf=1.
- Pixel (x=160, y=0) then (x=0, y=120) -> no fb_we, drop_count=2; stream stays ready.
- Pixel with last=1 at cycle N, vblank pulse at N+5 -> pixel_s_ready=0 from N+1; front_buf 0->1, fb_buf 1->0 and frame_done=1 at N+6; clear of buffer 0 follows.
- vblank pulse during DRAW, then last=1, then no vblank for 100 cycles -> no swap and ready held 0; the next vblank causes the swap.
- Assert rstn=0 midway through CLEAR (address 9000) -> outputs return to reset values immediately; after release the clear restarts at address 0 with front_buf=0.
